// File: rtl/cpu_seq_ctrl.sv
// Fetch/decode/execute sequencer for the 4-bit CPU: owns PC, IR and run/halt
// state, drives the external combinational ALU and registers its result.
module cpu_seq_ctrl #(
  parameter int unsigned PC_W     = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_en,
  input  logic [15:0]     imem_rdata,
  output logic [3:0]      alu_op,
  output logic [3:0]      alu_a,
  output logic [3:0]      alu_b,
  input  logic [3:0]      alu_result,
  output logic [3:0]      out,
  output logic            out_valid,
  output logic            busy,
  output logic            halted,
  output logic            illegal
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_EXEC,
    S_HALT
  } state_e;

  localparam logic [PC_W-1:0] PC_INIT = PC_W'(RESET_PC);
  localparam logic [3:0]      OP_JMP  = 4'hE;
  localparam logic [3:0]      OP_HALT = 4'hF;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic [3:0]      out_q, out_d;
  logic            out_valid_q, out_valid_d;
  logic            imem_en_q, imem_en_d;
  logic            busy_q, busy_d;
  logic            halted_q, halted_d;
  logic            illegal_q, illegal_d;
  logic [3:0]      alu_op_q, alu_op_d;
  logic [3:0]      alu_a_q, alu_a_d;
  logic [3:0]      alu_b_q, alu_b_d;

  logic [3:0] ir_op;
  logic [3:0] rd_op;
  logic       ir_is_alu;
  logic       ir_is_undef;
  logic       rd_is_alu;
  logic       unused_ir_bits;

  assign ir_op          = ir_q[15:12];
  assign rd_op          = imem_rdata[15:12];
  assign ir_is_alu      = (ir_op >= 4'h1) && (ir_op <= 4'h5);
  assign ir_is_undef    = (ir_op >= 4'h6) && (ir_op <= 4'hD);
  assign rd_is_alu      = (rd_op >= 4'h1) && (rd_op <= 4'h5);
  assign unused_ir_bits = ^ir_q[3:0];

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    illegal_d   = illegal_q;
    alu_op_d    = 4'h0;
    alu_a_d     = 4'h0;
    alu_b_d     = 4'h0;

    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        ir_d    = imem_rdata;
        pc_d    = pc_q + PC_W'(1);
        state_d = S_EXEC;
        // ALU drive is registered here so it is stable for the whole EXEC cycle
        if (rd_is_alu) begin
          alu_op_d = rd_op;
          alu_a_d  = imem_rdata[11:8];
          alu_b_d  = imem_rdata[7:4];
        end
      end
      S_EXEC: begin
        if (ir_is_alu) begin
          out_d       = alu_result;
          out_valid_d = 1'b1;
        end
        if (ir_op == OP_JMP) pc_d = PC_W'(ir_q[11:4]);
        if (ir_is_undef) illegal_d = 1'b1;
        state_d = (ir_op == OP_HALT) ? S_HALT : S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    imem_en_d = (state_d == S_FETCH);
    busy_d    = (state_d == S_FETCH) || (state_d == S_LOAD) || (state_d == S_EXEC);
    halted_d  = (state_d == S_HALT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= PC_INIT;
      ir_q        <= 16'h0000;
      out_q       <= 4'h0;
      out_valid_q <= 1'b0;
      imem_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
      illegal_q   <= 1'b0;
      alu_op_q    <= 4'h0;
      alu_a_q     <= 4'h0;
      alu_b_q     <= 4'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      imem_en_q   <= imem_en_d;
      busy_q      <= busy_d;
      halted_q    <= halted_d;
      illegal_q   <= illegal_d;
      alu_op_q    <= alu_op_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
    end
  end

  assign imem_addr = pc_q;
  assign imem_en   = imem_en_q;
  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign halted    = halted_q;
  assign illegal   = illegal_q;

endmodule

// File: doc/cpu_seq_ctrl.md
# cpu_seq_ctrl

Fetch/decode/execute sequencer for the 4-bit CPU datapath. It fetches 16-bit instruction words from a synchronous instruction memory, decodes them, drives the external combinational 4-bit ALU, and registers the result on `out`. The block owns the program counter, the instruction register and the run/halt state. It sits between the program memory and the ALU inside `cpu_main`.

## Interface
- `PC_W`, default 8: program counter width; must be at least 8.
- `RESET_PC`, default 0: PC value loaded on reset.
- `clk` input, 1 bit: single system clock; all state updates on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `start` input, 1 bit: a one-cycle pulse that begins execution from IDLE.
- `imem_addr` output, `PC_W` bits: instruction fetch address.
- `imem_en` output, 1 bit: fetch strobe.
- `imem_rdata` input, 16 bits: instruction word, valid the cycle after `imem_en` is high.
- `alu_op` output, 4 bits: ALU opcode.
- `alu_a` output, 4 bits: ALU operand A.
- `alu_b` output, 4 bits: ALU operand B.
- `alu_result` input, 4 bits: combinational ALU result.
- `out` output, 4 bits: last registered ALU result.
- `out_valid` output, 1 bit: one-cycle pulse when `out` updates.
- `busy` output, 1 bit: high in FETCH, LOAD and EXEC.
- `halted` output, 1 bit: high in HALT.
- `illegal` output, 1 bit: sticky flag, set when an undefined opcode is decoded.

## Operation
**Instruction word fields**
- [15:12] opcode.
- [11:8] A.
- [7:4] B.
- [3:0] reserved; ignored.

**Opcodes**
- 0x0 NOP.
- ALU operations: 0x1 ADD, 0x2 SUB, 0x3 AND, 0x4 OR, 0x5 XOR.
- 0xE JMP: target is {A,B}, zero-extended to `PC_W`.
- 0xF HALT.
- 0x6–0xD: undefined; executed as NOP and `illegal` is set.

**States**
- IDLE: `start` = 1 moves to FETCH.
- FETCH: `imem_addr` = PC, `imem_en` = 1. Always moves to LOAD.
- LOAD: IR <= `imem_rdata`, PC <= PC + 1 (modulo 2^`PC_W`). Moves to EXEC.
- EXEC, for opcodes 0x1–0x5:
  - `alu_op`/`alu_a`/`alu_b` = IR fields.
  - `out` <= `alu_result` at the end of the cycle; `out_valid` pulses the following cycle.
- EXEC, JMP: PC <= {A,B}.
- EXEC, NOP or undefined: `out` holds.
- EXEC next state: HALT for opcode 0xF, otherwise FETCH.
- HALT: holds until `rst`; `start` is ignored.

**Signal rules**
- Outside EXEC, `alu_op`/`alu_a`/`alu_b` = 0.
- In EXEC for opcodes other than 0x1–0x5, `alu_op`/`alu_a`/`alu_b` = 0.
- `imem_en` = 0 outside FETCH; `imem_addr` = PC at all times.
- `start` while `busy` or `halted` is ignored.
- The controller does no arithmetic on data. Width and wrap rules belong to the ALU; `out` is exactly `alu_result`.

## Timing
**Reset values** (reset has priority over every other input on the same edge):
- State = IDLE, PC = `RESET_PC`, IR = 0.
- `out` = 0, `out_valid` = 0, `busy` = 0, `halted` = 0, `illegal` = 0.
- `imem_en` = 0, `alu_*` = 0.

**Cycle counts**
- Every instruction takes exactly 3 cycles (FETCH, LOAD, EXEC); there are no stalls.
- First fetch is the cycle after `start` is sampled high.
- For an instruction fetched at cycle n, `out` is updated at the edge ending cycle n+2, and `out_valid` is high in cycle n+3.
- Back-to-back ALU instructions give an `out_valid` pulse every 3 cycles.

**Boundary conditions**
- PC wrap: PC = 2^`PC_W`−1 increments to 0.
- JMP to its own address loops forever with no `out_valid`.
- Reset asserted in any state, including mid-EXEC: the edge returns all state to reset values and the pending result is discarded.
- `illegal` clears only on reset.

## Test plan
- ADD: memory[0] = 0x1420, memory[1] = 0xF000, pulse `start`.
  - `alu_op` = 1, `alu_a` = 4, `alu_b` = 2 in EXEC; `out` = 6 with `out_valid` 3 cycles after the first fetch.
  - Then `halted` = 1, `busy` = 0.
- ADD then SUB: 0x1420, 0x2420, 0x2240, 0xF000 with a reference ALU model.
  - `out` sequence is 6, 2, 0xE; pulses are spaced 3 cycles apart.
- JMP: memory[0] = 0xE050, memory[5] = 0x1330, memory[6] = 0xF000.
  - Fetch addresses are 0, 5, 6; `out` = 6; addresses 1–4 are never fetched.
- Undefined and NOP: 0x7120, 0x0000, 0xF000.
  - `illegal` = 1 after the first EXEC; `out` stays 0; no `out_valid` pulse; HALT is reached.
  - `start` in HALT changes nothing.
- Reset mid-operation: assert `rst` during EXEC of 0x1420.
  - `out` stays 0, PC = 0, state = IDLE.
  - A new `start` re-fetches address 0.
- PC wrap: `RESET_PC` = 0xFF, memory[0xFF] = 0x1110, memory[0x00] = 0xF000.
  - Fetch addresses are 0xFF then 0x00; `out` = 2.
